// File: rtl/full_design.sv
// SPI-to-memory endpoint: SS_n-framed serial commands (MOSI sampled on clk) drive an
// internal 8-bit RAM, and read data is returned MSB first on MISO.
module full_design #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0] rx_data, rx_data_nxt;
    logic                  rx_valid, rx_valid_nxt;
    logic                  rd_addr_flag, rd_addr_flag_nxt;
    logic [CNT_W-1:0]      tx_cnt, tx_cnt_nxt;
    logic [DATA_W-1:0]     tx_shift, tx_shift_nxt;
    logic                  miso_nxt;

    logic [DATA_W-1:0]     mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0]  wr_addr, rd_addr;
    logic [DATA_W-1:0]     tx_data;
    logic                  tx_valid;

    logic [1:0]            rx_cmd;
    logic [DATA_W-1:0]     rx_payload;

    assign rx_cmd     = rx_data[FRAME_BITS-1:DATA_W];
    assign rx_payload = rx_data[DATA_W-1:0];

    // SPI slave state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_flag <= 1'b0;
            tx_cnt       <= '0;
            tx_shift     <= '0;
            MISO         <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            rd_addr_flag <= rd_addr_flag_nxt;
            tx_cnt       <= tx_cnt_nxt;
            tx_shift     <= tx_shift_nxt;
            MISO         <= miso_nxt;
        end
    end

    // Next-state: frame reception, then (READ_DATA only) byte shift-out.
    // tx_cnt: 0 = waiting for tx_valid, 1..8 = bit 7..0 on MISO, 9 = byte done.
    always_comb begin
        state_nxt        = state;
        bit_cnt_nxt      = bit_cnt;
        rx_data_nxt      = rx_data;
        rx_valid_nxt     = 1'b0;
        rd_addr_flag_nxt = rd_addr_flag;
        tx_cnt_nxt       = tx_cnt;
        tx_shift_nxt     = tx_shift;
        miso_nxt         = 1'b0;

        if (SS_n) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            tx_cnt_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt   = CHK_CMD;
                    bit_cnt_nxt = '0;
                    tx_cnt_nxt  = '0;
                end
                CHK_CMD: begin
                    if (!MOSI)
                        state_nxt = WRITE;
                    else if (rd_addr_flag)
                        state_nxt = READ_DATA;
                    else
                        state_nxt = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt < CNT_W'(FRAME_BITS)) begin
                        rx_data_nxt = {rx_data[FRAME_BITS-2:0], MOSI};
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            rx_valid_nxt = 1'b1;
                            if (state == READ_ADD)
                                rd_addr_flag_nxt = 1'b1;
                        end
                    end
                    if (state == READ_DATA) begin
                        if (tx_cnt == '0) begin
                            if (tx_valid) begin
                                miso_nxt     = tx_data[DATA_W-1];
                                tx_shift_nxt = {tx_data[DATA_W-2:0], 1'b0};
                                tx_cnt_nxt   = CNT_W'(1);
                            end
                        end else if (tx_cnt < CNT_W'(DATA_W)) begin
                            miso_nxt     = tx_shift[DATA_W-1];
                            tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
                            tx_cnt_nxt   = tx_cnt + CNT_W'(1);
                        end else if (tx_cnt == CNT_W'(DATA_W)) begin
                            rd_addr_flag_nxt = 1'b0;
                            tx_cnt_nxt       = CNT_W'(DATA_W + 1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // RAM control: address registers and read data, decoded from rx_data[9:8] alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                unique case (rx_cmd)
                    2'b00: wr_addr <= ADDR_SIZE'(rx_payload);
                    2'b01: ;
                    2'b10: rd_addr <= ADDR_SIZE'(rx_payload);
                    2'b11: begin
                        tx_data  <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory array is deliberately not reset
    always_ff @(posedge clk) begin
        if (rx_valid && rx_cmd == 2'b01)
            mem[wr_addr] <= rx_payload;
    end

endmodule

// File: tb/tb_full_design.sv
// Directed bench for full_design: reference RAM/flag model plus a queue of expected MISO bits.
module tb_full_design;

    logic clk = 1'b0;
    logic rst_n;
    logic MOSI;
    logic SS_n;
    logic MISO;

    always #5 clk = ~clk;

    full_design #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .MOSI (MOSI),
        .SS_n (SS_n),
        .MISO (MISO)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] model_mem [256];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    logic       m_flag;
    logic       exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives SS_n low, the path bit, then nbits frame bits; returns just after the last sampled bit
    task automatic start_frame(input logic path, input logic [9:0] f, input int nbits);
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk); MOSI = path;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); MOSI = f[9 - i];
        end
        @(negedge clk);
    endtask

    task automatic end_frame();
        SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk);
    endtask

    // Address/data command; early releases SS_n so it is already high at E13
    task automatic cmd_frame(input logic path, input logic [1:0] cmd, input logic [7:0] pl,
                             input logic early);
        logic to_read_add;
        to_read_add = path && !m_flag;
        start_frame(path, {cmd, pl}, 10);
        if (early) begin SS_n = 1'b1; MOSI = 1'b0; end
        @(negedge clk);
        case (cmd)
            2'b00: m_wr = pl;
            2'b01: model_mem[m_wr] = pl;
            2'b10: m_rd = pl;
            default: ;
        endcase
        if (to_read_add) m_flag = 1'b1;
        chk("wr_addr", 32'(dut.wr_addr), 32'(m_wr));
        chk("rd_addr", 32'(dut.rd_addr), 32'(m_rd));
        chk("rd_addr_flag", 32'(dut.rd_addr_flag), 32'(m_flag));
        end_frame();
    endtask

    // Read-data frame: expected bits queued at issue, popped as MISO presents them
    task automatic read_byte(input int stop_after);
        logic [7:0] b;
        b = model_mem[m_rd];
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        start_frame(1'b1, {2'b11, 8'($urandom_range(0, 255))}, 10);
        @(negedge clk);
        for (int k = 0; k < stop_after; k++) begin
            @(negedge clk);
            chk("miso_bit", 32'(MISO), 32'(exp_q.pop_front()));
        end
        if (stop_after == 8) begin
            @(negedge clk);
            m_flag = 1'b0;
            chk("miso_after_byte", 32'(MISO), 32'd0);
            chk("flag_cleared", 32'(dut.rd_addr_flag), 32'(m_flag));
            end_frame();
        end
    endtask

    task automatic read_at(input logic [7:0] addr);
        cmd_frame(1'b1, 2'b10, addr, 1'b0);
        read_byte(8);
    endtask

    task automatic write_at(input logic [7:0] addr, input logic [7:0] data);
        cmd_frame(1'b0, 2'b00, addr, 1'b0);
        cmd_frame(1'b0, 2'b01, data, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        m_wr = 8'h00; m_rd = 8'h00; m_flag = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_miso", 32'(MISO), 32'd0);
        chk("reset_state", 32'(3'(dut.state)), 32'd0);
        chk("reset_flag", 32'(dut.rd_addr_flag), 32'd0);
        chk("reset_tx_valid", 32'(dut.tx_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_miso", 32'(MISO), 32'd0);
        chk("idle_state", 32'(3'(dut.state)), 32'd0);
        chk("idle_rx_valid", 32'(dut.rx_valid), 32'd0);

        // Test-plan sequence at 0x0A
        write_at(8'h0A, 8'h0A);
        read_at(8'h0A);

        // Abort a write-data frame after 5 of its 10 bits
        start_frame(1'b0, {2'b01, 8'h55}, 5);
        end_frame();
        chk("abort_state", 32'(3'(dut.state)), 32'd0);
        chk("abort_rx_valid", 32'(dut.rx_valid), 32'd0);
        @(negedge clk);
        chk("abort_rx_valid2", 32'(dut.rx_valid), 32'd0);
        read_at(8'h0A);

        // Further patterns, including address extremes
        write_at(8'h3C, 8'hA5);
        write_at(8'hFF, 8'hE7);
        write_at(8'h00, 8'h7E);
        read_at(8'h3C);
        read_at(8'h00);
        read_at(8'hFF);

        // SS_n already high at E13 still completes the command
        cmd_frame(1'b0, 2'b00, 8'h81, 1'b1);
        cmd_frame(1'b0, 2'b01, 8'h96, 1'b1);
        read_at(8'h81);

        // Read-address command sent on the write path is executed; flag untouched
        cmd_frame(1'b0, 2'b10, 8'h3C, 1'b0);
        read_at(8'h3C);

        // Asynchronous reset in the middle of shifting out 0xE7
        cmd_frame(1'b1, 2'b10, 8'hFF, 1'b0);
        read_byte(3);
        rst_n = 1'b0;
        #1;
        m_wr = 8'h00; m_rd = 8'h00; m_flag = 1'b0;
        exp_q.delete();
        chk("arst_miso", 32'(MISO), 32'd0);
        chk("arst_state", 32'(3'(dut.state)), 32'd0);
        chk("arst_flag", 32'(dut.rd_addr_flag), 32'(m_flag));
        chk("arst_wr_addr", 32'(dut.wr_addr), 32'(m_wr));
        chk("arst_rd_addr", 32'(dut.rd_addr), 32'(m_rd));
        @(negedge clk);
        SS_n = 1'b1; MOSI = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        read_at(8'hFF);
        read_at(8'h0A);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
